// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one fixed-latency single-port memory between the fetch
// stage (IF) and the memory stage (DATA). One access runs at a time through
// IDLE -> ISSUE -> WAIT -> DONE. A one-cycle valid pulse goes back to the owner.
// DATA normally wins contention. IF is forced through after STARVE_LIMIT
// consecutive losses.
module imem_arbiter #(
  parameter int BIT_NUMBER   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [BIT_NUMBER-1:0] if_addr,
  input  logic                  if_flush,
  output logic [BIT_NUMBER-1:0] if_rdata,
  output logic                  if_valid,
  output logic                  freeze_if,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [BIT_NUMBER-1:0] mem_addr,
  input  logic [BIT_NUMBER-1:0] mem_wdata,
  output logic [BIT_NUMBER-1:0] mem_rdata,
  output logic                  mem_valid,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [BIT_NUMBER-1:0] ram_addr,
  output logic [BIT_NUMBER-1:0] ram_wdata,
  input  logic [BIT_NUMBER-1:0] ram_rdata
);

  localparam int LW = (MEM_LATENCY  > 1) ? $clog2(MEM_LATENCY + 1)  : 1;
  localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [LW-1:0] LAT_LOAD   = LW'(MEM_LATENCY);
  localparam logic [LW-1:0] LAT_ONE    = LW'(1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF   = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  state_t          state_r;
  state_t          state_nxt;
  owner_t          owner_r;
  logic            we_r;
  logic            kill_r;
  logic [LW-1:0]   lat_cnt_r;
  logic [SW-1:0]   starve_cnt_r;
  logic            if_valid_r;
  logic            fetch_req;
  logic            grant_if;
  logic            grant_data;
  logic            last_beat;

  // Next-state and grant decision; requests are only looked at in IDLE.
  always_comb begin
    state_nxt  = state_r;
    grant_if   = 1'b0;
    grant_data = 1'b0;
    fetch_req  = if_req & ~if_flush;
    last_beat  = 1'b0;
    case (state_r)
      IDLE: begin
        if (fetch_req && (!mem_req || (starve_cnt_r == STARVE_MAX))) begin
          grant_if  = 1'b1;
          state_nxt = ISSUE;
        end else if (mem_req) begin
          grant_data = 1'b1;
          state_nxt  = ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (lat_cnt_r == LAT_ONE) begin
          last_beat = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = WAIT;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Latch the granted access and drive the one-cycle memory strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_r   <= OWN_IF;
      we_r      <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= {BIT_NUMBER{1'b0}};
      ram_wdata <= {BIT_NUMBER{1'b0}};
    end else begin
      ram_en <= grant_if | grant_data;
      ram_we <= grant_data & mem_we;
      if (grant_if || grant_data) begin
        owner_r   <= grant_if ? OWN_IF : OWN_DATA;
        we_r      <= grant_data & mem_we;
        ram_addr  <= grant_if ? if_addr : mem_addr;
        ram_wdata <= mem_wdata;
      end
    end
  end

  // Latency countdown: loaded in ISSUE, counts down through WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_cnt_r <= {LW{1'b0}};
    end else if (state_r == ISSUE) begin
      lat_cnt_r <= LAT_LOAD;
    end else if ((state_r == WAIT) && (lat_cnt_r != {LW{1'b0}})) begin
      lat_cnt_r <= lat_cnt_r - LAT_ONE;
    end
  end

  // Count consecutive fetch losses; any fetch grant clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_r <= {SW{1'b0}};
    end else if (grant_if) begin
      starve_cnt_r <= {SW{1'b0}};
    end else if (grant_data && fetch_req && (starve_cnt_r != STARVE_MAX)) begin
      starve_cnt_r <= starve_cnt_r + SW'(1);
    end
  end

  // Kill flag: a flush during an IF access discards its result; cleared in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kill_r <= 1'b0;
    end else if (state_r == IDLE) begin
      kill_r <= 1'b0;
    end else if (if_flush && (owner_r == OWN_IF)) begin
      kill_r <= 1'b1;
    end
  end

  // Capture read data on the last WAIT beat and raise the owner's valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata   <= {BIT_NUMBER{1'b0}};
      mem_rdata  <= {BIT_NUMBER{1'b0}};
      if_valid_r <= 1'b0;
      mem_valid  <= 1'b0;
    end else begin
      if_valid_r <= last_beat && (owner_r == OWN_IF) && !kill_r && !if_flush;
      mem_valid  <= last_beat && (owner_r == OWN_DATA);
      if (last_beat && (owner_r == OWN_IF) && !kill_r && !if_flush) begin
        if_rdata <= ram_rdata;
      end
      if (last_beat && (owner_r == OWN_DATA) && !we_r) begin
        mem_rdata <= ram_rdata;
      end
    end
  end

  // A flush arriving in the DONE cycle still suppresses the fetch pulse.
  assign if_valid  = if_valid_r & ~if_flush;
  assign freeze_if = if_req & ~if_valid;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios followed by random traffic.
// A transaction-level timing model predicts every output each cycle.
module tb_imem_arbiter;

  localparam int LAT = 2;
  localparam int LIM = 2;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        freeze_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  imem_arbiter #(.BIT_NUMBER(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .freeze_if(freeze_if),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_val(input int i);
    logic [31:0] v;
    if (i == 16) return 32'hE3A01005;
    v = 32'(i) * 32'h9E3779B1;
    return v ^ 32'h5A5A0000;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  // Memory macro model: fixed latency, data present only in its valid cycle.
  logic [31:0] wr_val [256];
  bit          wr_flag [256];
  int          rd_cnt = 0;
  int          rd_idx = 0;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        wr_val[widx(ram_addr)]  <= ram_wdata;
        wr_flag[widx(ram_addr)] <= 1'b1;
      end
      rd_cnt <= LAT;
      rd_idx <= widx(ram_addr);
    end else if (rd_cnt != 0) begin
      rd_cnt <= rd_cnt - 1;
    end
  end

  assign ram_rdata = (rd_cnt == 1) ? (wr_flag[rd_idx] ? wr_val[rd_idx] : init_val(rd_idx))
                                   : 32'hBAD0BAD0;

  // Reference model state (transaction level).
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          m_busy, m_own_if, m_we, m_kill;
  logic [31:0] m_addr, m_wdata, m_last_addr, m_if_rd, m_mem_rd;
  int          m_t0, m_free, m_starve;
  logic [31:0] shadow [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_kill = 1'b0; m_starve = 0; m_free = cyc;
    m_last_addr = 32'd0; m_if_rd = 32'd0; m_mem_rd = 32'd0;
  endtask

  task automatic model_check();
    int  vc;
    bit  e_en, e_we, e_ifv, e_mv;
    vc    = m_t0 + 2 + LAT;
    e_en  = m_busy && (cyc == m_t0 + 1);
    e_we  = e_en && m_we;
    e_ifv = m_busy && m_own_if && (cyc == vc) && !m_kill && !if_flush;
    e_mv  = m_busy && !m_own_if && (cyc == vc);
    chk("ram_en", ram_en, e_en);
    chk("ram_we", ram_we, e_we);
    chk("ram_addr", ram_addr, m_last_addr);
    chk("if_valid", if_valid, e_ifv);
    chk("mem_valid", mem_valid, e_mv);
    chk("if_rdata", if_rdata, m_if_rd);
    chk("mem_rdata", mem_rdata, m_mem_rd);
    chk("freeze_if", freeze_if, if_req && !e_ifv);
    if (e_we) chk("ram_wdata", ram_wdata, m_wdata);
  endtask

  task automatic model_update();
    int vc;
    bit f;
    vc = m_t0 + 2 + LAT;
    if (m_busy) begin
      if (m_own_if && if_flush && (cyc >= m_t0 + 1)) m_kill = 1'b1;
      if ((cyc == m_t0 + 1) && m_we) shadow[widx(m_addr)] = m_wdata;
      if (cyc == vc - 1) begin
        if (m_own_if && !m_kill) m_if_rd = shadow[widx(m_addr)];
        if (!m_own_if && !m_we) m_mem_rd = shadow[widx(m_addr)];
      end
      if (cyc == vc) m_busy = 1'b0;
    end else if (cyc >= m_free) begin
      f = if_req && !if_flush;
      if (f && (!mem_req || m_starve == LIM)) begin
        m_busy = 1'b1; m_own_if = 1'b1; m_we = 1'b0; m_addr = if_addr;
        m_starve = 0;
      end else if (mem_req) begin
        m_busy = 1'b1; m_own_if = 1'b0; m_we = mem_we; m_addr = mem_addr;
        if (f && m_starve < LIM) m_starve++;
      end
      if (m_busy) begin
        m_t0 = cyc; m_free = cyc + 3 + LAT; m_kill = 1'b0;
        m_wdata = mem_wdata; m_last_addr = m_addr;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ram_en"}, ram_en, 32'd0);
    chk({tag, "_ram_we"}, ram_we, 32'd0);
    chk({tag, "_ram_addr"}, ram_addr, 32'd0);
    chk({tag, "_ram_wdata"}, ram_wdata, 32'd0);
    chk({tag, "_if_valid"}, if_valid, 32'd0);
    chk({tag, "_mem_valid"}, mem_valid, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_mem_rdata"}, mem_rdata, 32'd0);
  endtask

  int          s;
  logic [31:0] prev;

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    rst = 1'b0; if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
    #3;
    chk_zero_outputs("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();

    // Single fetch.
    s = cyc; if_req = 1'b1; if_addr = 32'h40; tick();
    chk("fetch_ram_en", ram_en, 32'd1);
    chk("fetch_ram_addr", ram_addr, 32'h40);
    wait_to(s + 4);
    chk("fetch_valid", if_valid, 32'd1);
    chk("fetch_rdata", if_rdata, 32'hE3A01005);
    chk("fetch_freeze", freeze_if, 32'd0);
    if_req = 1'b0; tick();

    // Contention: DATA first, then IF.
    s = cyc; if_req = 1'b1; if_addr = 32'h48;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100; tick();
    chk("cont_data_addr", ram_addr, 32'h100);
    wait_to(s + 4);
    chk("cont_mem_valid", mem_valid, 32'd1);
    mem_req = 1'b0;
    wait_to(s + 6);
    chk("cont_if_en", ram_en, 32'd1);
    chk("cont_if_addr", ram_addr, 32'h48);
    wait_to(s + 9);
    chk("cont_if_valid", if_valid, 32'd1);
    if_req = 1'b0; tick();

    // Starvation: DATA, DATA, then IF forced; counter cleared afterwards.
    s = cyc; if_req = 1'b1; if_addr = 32'hC0;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h104;
    wait_to(s + 1);  chk("starve_d1", ram_addr, 32'h104);
    wait_to(s + 6);  chk("starve_d2", ram_addr, 32'h104);
    wait_to(s + 11); chk("starve_if_en", ram_en, 32'd1);
    chk("starve_if_addr", ram_addr, 32'hC0);
    wait_to(s + 14); chk("starve_if_valid", if_valid, 32'd1);
    wait_to(s + 16); chk("starve_cleared", ram_addr, 32'h104);
    wait_to(s + 19); chk("starve_mem_valid", mem_valid, 32'd1);
    mem_req = 1'b0;
    wait_to(s + 24); chk("starve_if_valid2", if_valid, 32'd1);
    if_req = 1'b0; tick();

    // Flush during WAIT, then a new fetch to 0x80.
    s = cyc; prev = if_rdata; if_req = 1'b1; if_addr = 32'h60; tick();
    chk("flush_ram_en", ram_en, 32'd1);
    tick();
    if_flush = 1'b1; if_addr = 32'h80; tick();
    if_flush = 1'b0;
    wait_to(s + 4);
    chk("flush_no_valid", if_valid, 32'd0);
    chk("flush_rdata_kept", if_rdata, prev);
    wait_to(s + 9);
    chk("flush_refetch_valid", if_valid, 32'd1);
    chk("flush_refetch_rdata", if_rdata, init_val(32));
    if_req = 1'b0; tick();

    // Write then read.
    s = cyc; prev = mem_rdata;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h20; mem_wdata = 32'hDEADBEEF; tick();
    chk("wr_ram_we", ram_we, 32'd1);
    chk("wr_ram_wdata", ram_wdata, 32'hDEADBEEF);
    tick();
    chk("wr_ram_we_drop", ram_we, 32'd0);
    wait_to(s + 4);
    chk("wr_valid", mem_valid, 32'd1);
    chk("wr_rdata_kept", mem_rdata, prev);
    mem_we = 1'b0;
    wait_to(s + 9);
    chk("rd_valid", mem_valid, 32'd1);
    chk("rd_data", mem_rdata, 32'hDEADBEEF);
    mem_req = 1'b0; tick();

    // Reset in the middle of an access.
    s = cyc; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h24;
    wait_to(s + 2);
    rst = 1'b0; mem_req = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    @(posedge clk); #1; cyc++;
    @(posedge clk); #1; cyc++;
    rst = 1'b1;
    model_reset();
    repeat (6) tick();
    s = cyc; mem_req = 1'b1; mem_addr = 32'h28; tick();
    chk("postrst_en", ram_en, 32'd1);
    chk("postrst_addr", ram_addr, 32'h28);
    wait_to(s + 4);
    chk("postrst_valid", mem_valid, 32'd1);
    mem_req = 1'b0; tick();

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      if_req    = ($urandom_range(3) != 0);
      if_flush  = ($urandom_range(9) == 0);
      if_addr   = {22'd0, 8'($urandom), 2'd0};
      mem_req   = ($urandom_range(1) != 0);
      mem_we    = ($urandom_range(1) != 0);
      mem_addr  = {22'd0, 8'($urandom), 2'd0};
      mem_wdata = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
